// File: rtl/byte_entry_encoder.sv
`default_nettype none
// ============================================================================
// Module   : byte_entry_encoder
// Purpose  : Builds a signed 8-bit value from hex-digit switches and buttons,
//            echoing the entry in progress for the seven-segment path.
// Revision : 1.0 - initial release
// ============================================================================
module byte_entry_encoder #(
    parameter logic led_on  = 1'b0,
    parameter logic led_off = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_in,
    input  logic       btn_enter,
    input  logic       btn_sign,
    input  logic       btn_clear,
    output logic [7:0] num,
    output logic       valid,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       sign,
    output logic       ovf,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_LO  = 2'd1,
        S_CMT = 2'd2
    } state_t;

    localparam logic [7:0] c_pos_max = 8'h7F;
    localparam logic [7:0] c_neg_min = 8'h80;

    state_t     r_state, w_state_nxt;
    logic       r_enter_q, r_sign_q, r_clear_q;
    logic [3:0] r_d1, r_d0, w_d1_nxt, w_d0_nxt;
    logic       r_neg, w_neg_nxt;
    logic [7:0] r_num;
    logic       r_ovf, r_valid;
    logic       w_commit;
    logic [7:0] w_mag, w_cmt_num;
    logic       w_cmt_ovf;

    wire w_ev_enter = btn_enter & ~r_enter_q;
    wire w_ev_sign  = btn_sign  & ~r_sign_q;
    wire w_ev_clear = btn_clear & ~r_clear_q;

    // Clear wins over enter, enter wins over sign; the losers are dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_d1_nxt    = r_d1;
        w_d0_nxt    = r_d0;
        w_neg_nxt   = r_neg;
        w_commit    = 1'b0;
        if (w_ev_clear) begin
            w_state_nxt = S_HI;
            w_d1_nxt    = 4'h0;
            w_d0_nxt    = 4'h0;
            w_neg_nxt   = 1'b0;
        end else if (w_ev_enter) begin
            case (r_state)
                S_HI: begin
                    w_d1_nxt    = digit_in;
                    w_d0_nxt    = 4'h0;
                    w_neg_nxt   = 1'b0;
                    w_state_nxt = S_LO;
                end
                S_LO: begin
                    w_d0_nxt    = digit_in;
                    w_state_nxt = S_CMT;
                end
                S_CMT: begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_HI;
                end
                default: w_state_nxt = S_HI;
            endcase
        end else if (w_ev_sign) begin
            w_neg_nxt = ~r_neg;
        end
    end

    // Saturating magnitude-to-two's-complement conversion.
    always_comb begin
        w_mag     = {r_d1, r_d0};
        w_cmt_num = w_mag;
        w_cmt_ovf = 1'b0;
        if (!r_neg) begin
            if (w_mag > 8'd127) begin
                w_cmt_num = c_pos_max;
                w_cmt_ovf = 1'b1;
            end
        end else begin
            if (w_mag > 8'd128) begin
                w_cmt_num = c_neg_min;
                w_cmt_ovf = 1'b1;
            end else begin
                w_cmt_num = ~w_mag + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_HI;
            r_enter_q <= 1'b0;
            r_sign_q  <= 1'b0;
            r_clear_q <= 1'b0;
            r_d1      <= 4'h0;
            r_d0      <= 4'h0;
            r_neg     <= 1'b0;
            r_num     <= 8'h00;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_enter_q <= btn_enter;
            r_sign_q  <= btn_sign;
            r_clear_q <= btn_clear;
            r_d1      <= w_d1_nxt;
            r_d0      <= w_d0_nxt;
            r_neg     <= w_neg_nxt;
            r_valid   <= w_commit;
            if (w_commit) begin
                r_num <= w_cmt_num;
                r_ovf <= w_cmt_ovf;
            end
        end
    end

    assign num   = r_num;
    assign valid = r_valid;
    assign d1    = r_d1;
    assign d0    = r_d0;
    assign sign  = r_neg ? led_on : led_off;
    assign ovf   = r_ovf ? led_on : led_off;
    assign busy  = (r_state != S_HI);

endmodule
`default_nettype wire

// File: tb/tb_byte_entry_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_entry_encoder
// Purpose  : Directed vector table plus hand-written corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_entry_encoder;

    localparam logic c_on  = 1'b0;
    localparam logic c_off = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] digit_in;
    logic       btn_enter, btn_sign, btn_clear;
    logic [7:0] num;
    logic       valid;
    logic [3:0] d1, d0;
    logic       sign, ovf, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    int vbase;

    byte_entry_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digit_in (digit_in),
        .btn_enter(btn_enter),
        .btn_sign (btn_sign),
        .btn_clear(btn_clear),
        .num      (num),
        .valid    (valid),
        .d1       (d1),
        .d0       (d0),
        .sign     (sign),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (valid === 1'b1) vcnt++;

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       neg;
        logic [7:0] exp_num;
        logic       exp_ovf;
        logic       exp_sign;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive buttons for one sampling edge, then drop them; returns just after the edge.
    task automatic press(input logic e, input logic s, input logic c, input logic [3:0] d);
        digit_in  = d;
        btn_enter = e;
        btn_sign  = s;
        btn_clear = c;
        @(posedge clk); #1;
        btn_enter = 1'b0;
        btn_sign  = 1'b0;
        btn_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vecs[0] = '{4'h3, 4'hA, 1'b0, 8'h3A, c_off, c_off};
        vecs[1] = '{4'h7, 4'hF, 1'b1, 8'h81, c_off, c_on };
        vecs[2] = '{4'h8, 4'h0, 1'b1, 8'h80, c_off, c_on };
        vecs[3] = '{4'hF, 4'hF, 1'b0, 8'h7F, c_on,  c_off};
        vecs[4] = '{4'hF, 4'hF, 1'b1, 8'h80, c_on,  c_on };
        vecs[5] = '{4'h0, 4'h0, 1'b1, 8'h00, c_off, c_on };
        vecs[6] = '{4'h8, 4'h0, 1'b0, 8'h7F, c_on,  c_off};
        vecs[7] = '{4'h8, 4'h1, 1'b1, 8'h80, c_on,  c_on };
        vecs[8] = '{4'h0, 4'h1, 1'b1, 8'hFF, c_off, c_on };

        rst_n = 1'b0; digit_in = 4'h0;
        btn_enter = 1'b0; btn_sign = 1'b0; btn_clear = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        chk("reset num",   num,   8'h00);
        chk("reset valid", valid, 1'b0);
        chk("reset d1",    d1,    4'h0);
        chk("reset d0",    d0,    4'h0);
        chk("reset sign",  sign,  c_off);
        chk("reset ovf",   ovf,   c_off);
        chk("reset busy",  busy,  1'b0);

        for (int i = 0; i < 9; i++) begin
            press(1, 0, 0, vecs[i].hi); idle(1);
            chk("hi d1",   d1,   vecs[i].hi);
            chk("hi busy", busy, 1'b1);
            if (vecs[i].neg) begin
                press(0, 1, 0, 4'h0); idle(1);
            end
            press(1, 0, 0, vecs[i].lo); idle(1);
            chk("lo d0", d0, vecs[i].lo);
            vbase = vcnt;
            press(1, 0, 0, 4'h0);
            chk("commit valid", valid, 1'b1);
            chk("commit num",   num,   vecs[i].exp_num);
            idle(1);
            chk("valid drop", valid, 1'b0);
            idle(2);
            chk("valid count", vcnt - vbase, 1);
            chk("commit ovf",  ovf,  vecs[i].exp_ovf);
            chk("commit sign", sign, vecs[i].exp_sign);
            chk("commit busy", busy, 1'b0);
            chk("num held",    num,  vecs[i].exp_num);
        end

        // Held enter gives a single event; clear in S_LO aborts without touching num.
        vbase = vcnt;
        digit_in = 4'h5; btn_enter = 1'b1;
        idle(20);
        btn_enter = 1'b0;
        idle(1);
        chk("hold d1",   d1,   4'h5);
        chk("hold d0",   d0,   4'h0);
        chk("hold busy", busy, 1'b1);
        press(0, 1, 0, 4'h0); idle(1);
        chk("sign toggle on", sign, c_on);
        press(0, 1, 0, 4'h0); idle(1);
        chk("sign toggle off", sign, c_off);
        press(0, 0, 1, 4'h0); idle(1);
        chk("clear busy", busy, 1'b0);
        chk("clear d1",   d1,   4'h0);
        chk("clear d0",   d0,   4'h0);
        chk("clear num",  num,  8'hFF);
        chk("clear ovf",  ovf,  c_off);
        chk("clear no valid", vcnt - vbase, 0);

        // Clear coincident with enter in S_CMT.
        press(1, 0, 0, 4'h1); idle(1);
        press(1, 0, 0, 4'h2); idle(1);
        chk("cmt busy", busy, 1'b1);
        vbase = vcnt;
        press(1, 0, 1, 4'h0); idle(3);
        chk("clr+ent busy",  busy, 1'b0);
        chk("clr+ent d1",    d1,   4'h0);
        chk("clr+ent num",   num,  8'hFF);
        chk("clr+ent valid", vcnt - vbase, 0);

        // Enter coincident with sign in S_HI: digit taken, sign dropped.
        press(1, 1, 0, 4'h6); idle(1);
        chk("ent+sign d1",   d1,   4'h6);
        chk("ent+sign busy", busy, 1'b1);
        chk("ent+sign sign", sign, c_off);

        // Asynchronous reset while waiting for commit.
        press(1, 0, 0, 4'h4); idle(1);
        press(0, 1, 0, 4'h0); idle(1);
        chk("pre-reset busy", busy, 1'b1);
        vbase = vcnt;
        #2 rst_n = 1'b0;
        #1;
        chk("async num",  num,  8'h00);
        chk("async busy", busy, 1'b0);
        chk("async d1",   d1,   4'h0);
        chk("async d0",   d0,   4'h0);
        chk("async sign", sign, c_off);
        chk("async ovf",  ovf,  c_off);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("async no valid", vcnt - vbase, 0);
        chk("async valid",    valid, 1'b0);

        // Enter held through reset release produces an event on the first edge.
        digit_in = 4'h9; btn_enter = 1'b1;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("held rst busy", busy, 1'b1);
        chk("held rst d1",   d1,   4'h9);
        btn_enter = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
